// File: rtl/quat_mult_seq_if.sv
// Operand/result handshake bundle for quat_mult_seq.
// With QMUL_CONJ_EN defined the bundle also carries conj_i.
interface quat_mult_seq_if #(
    parameter int W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   a1, b1, c1, d1;
    logic signed [W-1:0]   a2, b2, c2, d2;
`ifdef QMUL_CONJ_EN
    logic                  conj_i;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W+1:0] r1, r2, r3, r4;

`ifdef QMUL_CONJ_EN
    modport slave (
        input  in_valid, a1, b1, c1, d1, a2, b2, c2, d2, conj_i, out_ready,
        output in_ready, out_valid, r1, r2, r3, r4
    );
    modport master (
        output in_valid, a1, b1, c1, d1, a2, b2, c2, d2, conj_i, out_ready,
        input  in_ready, out_valid, r1, r2, r3, r4
    );
`else
    modport slave (
        input  in_valid, a1, b1, c1, d1, a2, b2, c2, d2, out_ready,
        output in_ready, out_valid, r1, r2, r3, r4
    );
    modport master (
        output in_valid, a1, b1, c1, d1, a2, b2, c2, d2, out_ready,
        input  in_ready, out_valid, r1, r2, r3, r4
    );
`endif
endinterface

// File: rtl/quat_mult_seq.sv
// Sequential Hamilton product q1*q2 over MULS time-shared signed multipliers, L = 16/MULS cycles.
// Optional QMUL_CONJ_EN: conj_i at acceptance selects q1*conj(q2).
module quat_mult_seq #(
    parameter int W    = 16,
    parameter int MULS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    quat_mult_seq_if.slave bus
);
    localparam int L  = 16 / MULS;
    localparam int RW = 2 * W + 2;
    localparam int PW = 2 * W + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  q1_q  [4];
    logic signed [W-1:0]  q1_d  [4];
    logic signed [W:0]    q2_q  [4];
    logic signed [W:0]    q2_d  [4];
    logic signed [RW-1:0] acc_q [4];
    logic signed [RW-1:0] acc_d [4];
    logic signed [RW-1:0] res_q [4];
    logic signed [RW-1:0] res_d [4];
    logic [4:0]           cnt_q, cnt_d;
    logic [3:0]           idx;
    logic [1:0]           grp, trm;
    logic signed [PW-1:0] prod;
    logic                 conj;
    logic                 in_ready, out_valid;

`ifdef QMUL_CONJ_EN
    assign conj = bus.conj_i;
`else
    assign conj = 1'b0;
`endif

    // Product k feeds result k/4; q1 term is k%4 and the q2 term is (k/4) xor (k%4).
    function automatic logic term_neg(input logic [1:0] g, input logic [1:0] t);
        case (g)
            2'd0:    return t != 2'd0;
            2'd1:    return t == 2'd3;
            2'd2:    return t == 2'd1;
            default: return t == 2'd2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        acc_d     = acc_q;
        res_d     = res_q;
        idx       = '0;
        grp       = '0;
        trm       = '0;
        prod      = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    q1_d[0] = bus.a1;
                    q1_d[1] = bus.b1;
                    q1_d[2] = bus.c1;
                    q1_d[3] = bus.d1;
                    // Negation at W+1 bits keeps -(-2^(W-1)) exact.
                    q2_d[0] = (W+1)'(bus.a2);
                    q2_d[1] = conj ? -((W+1)'(bus.b2)) : (W+1)'(bus.b2);
                    q2_d[2] = conj ? -((W+1)'(bus.c2)) : (W+1)'(bus.c2);
                    q2_d[3] = conj ? -((W+1)'(bus.d2)) : (W+1)'(bus.d2);
                    for (int i = 0; i < 4; i++) acc_d[i] = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int m = 0; m < MULS; m++) begin
                    idx  = 4'(int'(cnt_q) * MULS + m);
                    grp  = idx[3:2];
                    trm  = idx[1:0];
                    prod = PW'(q1_q[trm]) * PW'(q2_q[grp ^ trm]);
                    if (term_neg(grp, trm)) acc_d[grp] = acc_d[grp] - RW'(prod);
                    else                    acc_d[grp] = acc_d[grp] + RW'(prod);
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(L - 1)) begin
                    res_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.r1        = res_q[0];
    assign bus.r2        = res_q[1];
    assign bus.r3        = res_q[2];
    assign bus.r4        = res_q[3];
endmodule
